// File: rtl/global_predictor.sv
// global_predictor: global half of a tournament branch predictor (path history, global and choice tables).
// Optional GLOBAL_MISPREDICT_CNT_EN adds a saturating global-mispredict counter output.
module global_predictor #(
  parameter int         HIST_W = 12,
  parameter logic [1:0] GINIT  = 2'b01,
  parameter logic [1:0] CINIT  = 2'b01
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        BranchTaken,
  input  logic        PredictedBranch,
  output logic        Globalbit,
`ifdef GLOBAL_MISPREDICT_CNT_EN
  output logic        Choicebit,
  output logic [15:0] mispredict_count
`else
  output logic        Choicebit
`endif
);
  localparam int N = 2 ** HIST_W;
  logic [HIST_W-1:0] r_hist;
  logic [1:0]        r_gpt [N];
  logic [1:0]        r_cpt [N];
  logic [1:0]        w_g, w_c, w_g_nxt, w_c_nxt;
  logic              w_gbit;
  assign w_g       = r_gpt[r_hist];
  assign w_c       = r_cpt[r_hist];
  assign w_gbit    = w_g[1];
  assign Globalbit = w_gbit;
  assign Choicebit = w_c[1];
  always_comb begin
    w_g_nxt = BranchTaken ? ((w_g == 2'b11) ? w_g : w_g + 2'd1)
                          : ((w_g == 2'b00) ? w_g : w_g - 2'd1);
    // choice only learns when the two predictors disagree
    w_c_nxt = (w_gbit == PredictedBranch) ? w_c
            : (w_gbit == BranchTaken)     ? ((w_c == 2'b11) ? w_c : w_c + 2'd1)
                                          : ((w_c == 2'b00) ? w_c : w_c - 2'd1);
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_hist <= '0;
      for (int i = 0; i < N; i++) begin
        r_gpt[i] <= GINIT;
        r_cpt[i] <= CINIT;
      end
    end else begin
      r_gpt[r_hist] <= w_g_nxt;
      r_cpt[r_hist] <= w_c_nxt;
      r_hist        <= {r_hist[HIST_W-2:0], BranchTaken};
    end
  end
`ifdef GLOBAL_MISPREDICT_CNT_EN
  logic [15:0] r_mis;
  assign mispredict_count = r_mis;
  always_ff @(posedge clock) begin
    if (!reset)
      r_mis <= '0;
    else if (w_gbit != BranchTaken && r_mis != 16'hFFFF)
      r_mis <= r_mis + 16'd1;
  end
`endif
endmodule

// File: tb/tb_global_predictor.sv
// tb_global_predictor: directed vector table plus randomized run against a table-level model.
module tb_global_predictor;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic BranchTaken = 1'b0;
  logic PredictedBranch = 1'b0;
  logic Globalbit, Choicebit;
`ifdef GLOBAL_MISPREDICT_CNT_EN
  logic [15:0] mispredict_count;
`endif
  int checks = 0;
  int errors = 0;
  int gm [4096];
  int cm [4096];
  int hm = 0;
  int cntm = 0;

  global_predictor dut (
    .clock           (clock),
    .reset           (reset),
    .BranchTaken     (BranchTaken),
    .PredictedBranch (PredictedBranch),
    .Globalbit       (Globalbit),
`ifdef GLOBAL_MISPREDICT_CNT_EN
    .Choicebit       (Choicebit),
    .mispredict_count(mispredict_count)
`else
    .Choicebit       (Choicebit)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    bit r, bt, pb, g, c;
    int cnt;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, advance the model from the spec's counter rules, compare outputs.
  task automatic step(input bit r, input bit bt, input bit pb);
    bit g;
    reset = r; BranchTaken = bt; PredictedBranch = pb;
    @(posedge clock); #1;
    if (!r) begin
      for (int i = 0; i < 4096; i++) begin gm[i] = 1; cm[i] = 1; end
      hm = 0; cntm = 0;
    end else begin
      g = gm[hm] >= 2;
      if (g != bt && cntm < 65535) cntm++;
      if (g != pb) cm[hm] = (g == bt) ? ((cm[hm] < 3) ? cm[hm] + 1 : 3)
                                      : ((cm[hm] > 0) ? cm[hm] - 1 : 0);
      gm[hm] = bt ? ((gm[hm] < 3) ? gm[hm] + 1 : 3) : ((gm[hm] > 0) ? gm[hm] - 1 : 0);
      hm = ((hm * 2) + int'(bt)) % 4096;
    end
    chk("model_glob", int'(Globalbit), int'(gm[hm] >= 2));
    chk("model_choice", int'(Choicebit), int'(cm[hm] >= 2));
`ifdef GLOBAL_MISPREDICT_CNT_EN
    chk("model_cnt", int'(mispredict_count), cntm);
`endif
  endtask

  initial begin
    tbl.push_back('{r:0, bt:0, pb:0, g:0, c:0, cnt:0});
    for (int k = 0; k < 12; k++) tbl.push_back('{r:1, bt:1, pb:1, g:0, c:0, cnt:k + 1});
    tbl.push_back('{r:1, bt:1, pb:1, g:1, c:0, cnt:13});
    tbl.push_back('{r:1, bt:1, pb:1, g:1, c:0, cnt:13});
    tbl.push_back('{r:1, bt:1, pb:1, g:1, c:0, cnt:13});
    tbl.push_back('{r:0, bt:1, pb:1, g:0, c:0, cnt:0});
    tbl.push_back('{r:1, bt:0, pb:0, g:0, c:0, cnt:0});
    tbl.push_back('{r:1, bt:0, pb:0, g:0, c:0, cnt:0});
    tbl.push_back('{r:1, bt:0, pb:1, g:0, c:1, cnt:0});
    tbl.push_back('{r:1, bt:0, pb:1, g:0, c:1, cnt:0});
    tbl.push_back('{r:1, bt:1, pb:0, g:0, c:0, cnt:1});
    tbl.push_back('{r:1, bt:0, pb:0, g:0, c:0, cnt:1});

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].bt, tbl[i].pb);
      chk($sformatf("vec%0d_glob", i), int'(Globalbit), int'(tbl[i].g));
      chk($sformatf("vec%0d_choice", i), int'(Choicebit), int'(tbl[i].c));
`ifdef GLOBAL_MISPREDICT_CNT_EN
      chk($sformatf("vec%0d_cnt", i), int'(mispredict_count), tbl[i].cnt);
`endif
    end

    // Mid-run reset after reaching history FFF: the FFF entry must be back to weak not-taken.
    step(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) step(1'b1, 1'b1, 1'b0);
    chk("fresh_fff_glob", int'(Globalbit), 0);
    step(1'b1, 1'b1, 1'b0);
    chk("fff_after_train_glob", int'(Globalbit), 1);

    // Biased random outcomes revisit indices so counters reach saturation.
    for (int n = 0; n < 4000; n++)
      step($urandom_range(0, 199) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
